multi_prescale_counter: RTL and testbench

Parametrised N-channel event counter. Each enabled cycle is one event, steered to one channel by Sel. Every channel has a runtime-programmable prescaler (divide by div+1), a CW-bit count, wrap or saturate mode, a sticky overflow flag, a terminal-tick pulse and a per-channel clear. It sits in the debug/statistics path as the general counter block. With the default parameters it reproduces the two-counter scheme: channel 0 counts every event, channel 1 counts every 4th.

---
 rtl/multi_prescale_counter.sv | 116 +++++++++++
 tb/tb_multi_prescale_counter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_prescale_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multi_prescale_counter
//  Purpose  : N-channel event counter. Each enabled cycle is one event,
//             steered to one channel by Sel. Every channel owns a
//             programmable prescaler (divide by div+1), a CW-bit count
//             (wrap or saturate), a sticky overflow flag, a one-cycle
//             terminal tick and a synchronous clear.
//  Ports    : Clk      - clock, all state updates on the rising edge
//             Reset    - synchronous, active-high
//             En       - event qualifier
//             Sel      - target channel of the current event
//             Clr      - per-channel synchronous clear (NCH bits)
//             Cfg_we   - divider write strobe
//             Cfg_ch   - divider write channel
//             Cfg_div  - divider value (count once per Cfg_div+1 events)
//             Count    - channel i at [i*CW +: CW], registered
//             Ovf      - sticky overflow/saturation flags, registered
//             Tick     - one-cycle terminal pulses, registered
//  Revision : 1.0 - initial release
// ============================================================================
module multi_prescale_counter #(
    parameter  int NCH       = 2,
    parameter  int CW        = 64,
    parameter  int PW        = 4,
    parameter  int SAT       = 0,
    parameter  int DIV1_INIT = 3,
    localparam int SW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [SW-1:0]     Sel,
    input  logic [NCH-1:0]    Clr,
    input  logic              Cfg_we,
    input  logic [SW-1:0]     Cfg_ch,
    input  logic [PW-1:0]     Cfg_div,
    output logic [NCH*CW-1:0] Count,
    output logic [NCH-1:0]    Ovf,
    output logic [NCH-1:0]    Tick
);

    localparam bit c_sat = (SAT != 0);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [SW-1:0] c_idx     = SW'(i);
        // Channel 0 counts every event out of reset; the others divide.
        localparam logic [PW-1:0] c_div_rst = (i == 0) ? PW'(0) : PW'(DIV1_INIT);

        logic [CW-1:0] r_cnt;
        logic [PW-1:0] r_pre;
        logic [PW-1:0] r_div;
        logic          r_ovf;
        logic          r_tick;

        logic          w_ev;
        logic          w_wr;
        logic          w_term;
        logic          w_full;

        // A select or write channel beyond NCH-1 matches no channel, so
        // out-of-range traffic falls through with no state change.
        assign w_ev   = En && (Sel == c_idx);
        assign w_wr   = Cfg_we && (Cfg_ch == c_idx);
        // Every divider write zeroes pre, so pre can never pass div and
        // an equality compare is sufficient.
        assign w_term = (r_pre == r_div);
        assign w_full = &r_cnt;

        // Priority: Reset > Clr > divider write > event.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cnt  <= '0;
                r_pre  <= '0;
                r_div  <= c_div_rst;
                r_ovf  <= 1'b0;
                r_tick <= 1'b0;
            end else if (Clr[i]) begin
                r_cnt  <= '0;
                r_pre  <= '0;
                r_ovf  <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_wr) begin
                r_div  <= Cfg_div;
                r_pre  <= '0;
                r_tick <= 1'b0;
            end else if (w_ev) begin
                if (!w_term) begin
                    r_pre  <= r_pre + PW'(1);
                    r_tick <= 1'b0;
                end else begin
                    r_pre  <= '0;
                    r_tick <= 1'b1;
                    if (w_full) begin
                        // Saturating mode holds at all-ones; wrapping mode
                        // rolls to zero. Both flag the event as overflow.
                        r_ovf <= 1'b1;
                        if (!c_sat) begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end else begin
                r_tick <= 1'b0;
            end
        end

        assign Count[i*CW +: CW] = r_cnt;
        assign Ovf[i]            = r_ovf;
        assign Tick[i]           = r_tick;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_prescale_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_prescale_counter
//  Purpose  : Self-checking bench for multi_prescale_counter. Three builds
//             run side by side on one clock:
//               A - defaults (NCH=2, CW=64, wrap)
//               B - NCH=3, CW=4, wrap
//               C - NCH=2, CW=4, saturate
//             A behavioural model predicts every output each cycle; the
//             prediction is queued when stimulus is driven and popped when
//             the outputs are sampled. Hand-computed tables and sequences
//             add independent checks of the documented scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_prescale_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A ----------------
    logic         a_rst, a_en, a_we;
    logic [0:0]   a_sel, a_cfg_ch;
    logic [1:0]   a_clr;
    logic [3:0]   a_cfg_div;
    logic [127:0] a_count;
    logic [1:0]   a_ovf, a_tick;

    multi_prescale_counter u_a (
        .Clk(clk), .Reset(a_rst), .En(a_en), .Sel(a_sel), .Clr(a_clr),
        .Cfg_we(a_we), .Cfg_ch(a_cfg_ch), .Cfg_div(a_cfg_div),
        .Count(a_count), .Ovf(a_ovf), .Tick(a_tick)
    );

    // ---------------- DUT B ----------------
    logic         b_rst, b_en, b_we;
    logic [1:0]   b_sel, b_cfg_ch;
    logic [2:0]   b_clr;
    logic [3:0]   b_cfg_div;
    logic [11:0]  b_count;
    logic [2:0]   b_ovf, b_tick;

    multi_prescale_counter #(.NCH(3), .CW(4), .PW(4), .SAT(0), .DIV1_INIT(3)) u_b (
        .Clk(clk), .Reset(b_rst), .En(b_en), .Sel(b_sel), .Clr(b_clr),
        .Cfg_we(b_we), .Cfg_ch(b_cfg_ch), .Cfg_div(b_cfg_div),
        .Count(b_count), .Ovf(b_ovf), .Tick(b_tick)
    );

    // ---------------- DUT C ----------------
    logic         c_rst, c_en, c_we;
    logic [0:0]   c_sel, c_cfg_ch;
    logic [1:0]   c_clr;
    logic [3:0]   c_cfg_div;
    logic [7:0]   c_count;
    logic [1:0]   c_ovf, c_tick;

    multi_prescale_counter #(.NCH(2), .CW(4), .PW(4), .SAT(1), .DIV1_INIT(3)) u_c (
        .Clk(clk), .Reset(c_rst), .En(c_en), .Sel(c_sel), .Clr(c_clr),
        .Cfg_we(c_we), .Cfg_ch(c_cfg_ch), .Cfg_div(c_cfg_div),
        .Count(c_count), .Ovf(c_ovf), .Tick(c_tick)
    );

    // ---------------- stimulus / model types ----------------
    typedef struct packed {
        logic       rst;
        logic       en;
        logic [1:0] sel;
        logic [2:0] clr;
        logic       we;
        logic [1:0] cfg_ch;
        logic [3:0] cfg_div;
    } stim_t;

    typedef struct packed {
        logic [2:0][63:0] cnt;
        logic [2:0][3:0]  pre;
        logic [2:0][3:0]  div;
        logic [2:0]       ovf;
        logic [2:0]       tick;
    } model_t;

    typedef struct packed {
        model_t a;
        model_t b;
        model_t c;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        int         reps;
        logic [63:0] c0;
        logic [63:0] c1;
        logic       t0;
        logic       t1;
    } vec_t;

    model_t mA = '0, mB = '0, mC = '0;
    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Next-state prediction of one counter build for one clock edge.
    function automatic model_t step(model_t m, int nch, int cw, bit sat, stim_t s);
        model_t      n   = m;
        logic [63:0] top = (cw >= 64) ? {64{1'b1}} : ((64'd1 << cw) - 64'd1);
        for (int ch = 0; ch < nch; ch++) begin
            if (s.rst) begin
                n.cnt[ch] = '0; n.pre[ch] = '0; n.ovf[ch] = 1'b0; n.tick[ch] = 1'b0;
                n.div[ch] = (ch == 0) ? 4'd0 : 4'd3;
            end else if (s.clr[ch]) begin
                n.cnt[ch] = '0; n.pre[ch] = '0; n.ovf[ch] = 1'b0; n.tick[ch] = 1'b0;
            end else if (s.we && int'(s.cfg_ch) == ch) begin
                n.div[ch] = s.cfg_div; n.pre[ch] = '0; n.tick[ch] = 1'b0;
            end else if (s.en && int'(s.sel) == ch) begin
                if (m.pre[ch] != m.div[ch]) begin
                    n.pre[ch]  = m.pre[ch] + 4'd1;
                    n.tick[ch] = 1'b0;
                end else begin
                    n.pre[ch]  = '0;
                    n.tick[ch] = 1'b1;
                    if (m.cnt[ch] == top) begin
                        n.ovf[ch] = 1'b1;
                        if (!sat) n.cnt[ch] = '0;
                    end else begin
                        n.cnt[ch] = m.cnt[ch] + 64'd1;
                    end
                end
            end else begin
                n.tick[ch] = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle on all three builds, queue the prediction, then sample
    // the outputs one time unit after the edge and compare.
    task automatic drive(input stim_t sa, input stim_t sb, input stim_t sc);
        exp_t e;
        a_rst = sa.rst; a_en = sa.en; a_sel = sa.sel[0]; a_clr = sa.clr[1:0];
        a_we = sa.we; a_cfg_ch = sa.cfg_ch[0]; a_cfg_div = sa.cfg_div;
        b_rst = sb.rst; b_en = sb.en; b_sel = sb.sel; b_clr = sb.clr;
        b_we = sb.we; b_cfg_ch = sb.cfg_ch; b_cfg_div = sb.cfg_div;
        c_rst = sc.rst; c_en = sc.en; c_sel = sc.sel[0]; c_clr = sc.clr[1:0];
        c_we = sc.we; c_cfg_ch = sc.cfg_ch[0]; c_cfg_div = sc.cfg_div;
        mA = step(mA, 2, 64, 1'b0, sa);
        mB = step(mB, 3, 4, 1'b0, sb);
        mC = step(mC, 2, 4, 1'b1, sc);
        sb_q.push_back('{a: mA, b: mB, c: mC});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        for (int ch = 0; ch < 2; ch++)
            chk($sformatf("A.count%0d", ch), a_count[ch*64 +: 64], e.a.cnt[ch]);
        chk("A.ovf",  {62'd0, a_ovf},  {62'd0, e.a.ovf[1:0]});
        chk("A.tick", {62'd0, a_tick}, {62'd0, e.a.tick[1:0]});
        for (int ch = 0; ch < 3; ch++)
            chk($sformatf("B.count%0d", ch), {60'd0, b_count[ch*4 +: 4]}, e.b.cnt[ch]);
        chk("B.ovf",  {61'd0, b_ovf},  {61'd0, e.b.ovf});
        chk("B.tick", {61'd0, b_tick}, {61'd0, e.b.tick});
        for (int ch = 0; ch < 2; ch++)
            chk($sformatf("C.count%0d", ch), {60'd0, c_count[ch*4 +: 4]}, e.c.cnt[ch]);
        chk("C.ovf",  {62'd0, c_ovf},  {62'd0, e.c.ovf[1:0]});
        chk("C.tick", {62'd0, c_tick}, {62'd0, e.c.tick[1:0]});
    endtask

    function automatic stim_t ev(input logic [1:0] sel);
        stim_t s = '0;
        s.en  = 1'b1;
        s.sel = sel;
        return s;
    endfunction

    function automatic stim_t wr(input logic [1:0] ch, input logic [3:0] div);
        stim_t s = '0;
        s.we      = 1'b1;
        s.cfg_ch  = ch;
        s.cfg_div = div;
        return s;
    endfunction

    // Watchdog: the stimulus never waits on the DUT, but keep the run bounded.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        vec_t  tbl[8];

        tbl[0] = '{1'b1, 2'd0, 10, 64'd10, 64'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 2'd1, 3,  64'd10, 64'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2'd1, 1,  64'd10, 64'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 2'd1, 1,  64'd10, 64'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 2,  64'd10, 64'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'd1, 1,  64'd10, 64'd2, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'd1, 2,  64'd10, 64'd2, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 3,  64'd10, 64'd2, 1'b0, 1'b0};

        // ---- reset all builds ----
        s = '0; s.rst = 1'b1;
        drive(s, s, s);
        drive(s, s, s);
        chk("A.reset.count", a_count[63:0] | a_count[127:64], 64'd0);
        chk("B.reset.ovf_tick", {58'd0, b_ovf, b_tick}, 64'd0);

        // ---- A: 10 events on ch0, then 10 on ch1 (div1=3) ----
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                s = '0; s.en = tbl[v].en; s.sel = tbl[v].sel;
                drive(s, '0, '0);
            end
            chk($sformatf("tbl%0d.count0", v), a_count[63:0],   tbl[v].c0);
            chk($sformatf("tbl%0d.count1", v), a_count[127:64], tbl[v].c1);
            chk($sformatf("tbl%0d.tick0", v),  {63'd0, a_tick[0]}, {63'd0, tbl[v].t0});
            chk($sformatf("tbl%0d.tick1", v),  {63'd0, a_tick[1]}, {63'd0, tbl[v].t1});
        end

        // ---- B wraps / C saturates on ch0 with div0=0, 17 events ----
        for (int i = 1; i <= 17; i++) begin
            drive('0, ev(2'd0), ev(2'd0));
            if (i == 15) begin
                chk("wrap15.B.count0", {60'd0, b_count[3:0]}, 64'd15);
                chk("wrap15.B.ovf0",   {63'd0, b_ovf[0]},     64'd0);
            end
            if (i == 16) begin
                chk("wrap16.B.count0", {60'd0, b_count[3:0]}, 64'd0);
                chk("wrap16.B.ovf0",   {63'd0, b_ovf[0]},     64'd1);
                chk("sat16.C.count0",  {60'd0, c_count[3:0]}, 64'd15);
                chk("sat16.C.ovf0",    {63'd0, c_ovf[0]},     64'd1);
            end
            if (i == 17) begin
                chk("wrap17.B.count0", {60'd0, b_count[3:0]}, 64'd1);
                chk("sat17.C.count0",  {60'd0, c_count[3:0]}, 64'd15);
                chk("sat17.C.tick0",   {63'd0, c_tick[0]},    64'd1);
            end
        end

        // ---- A: divider write to ch1 drops a same-cycle ch1 event ----
        s = wr(2'd1, 4'd1); s.en = 1'b1; s.sel = 2'd1;
        drive(s, '0, '0);
        chk("cfg.drop.count1", a_count[127:64], 64'd2);
        chk("cfg.drop.tick1",  {63'd0, a_tick[1]}, 64'd0);
        drive(ev(2'd1), '0, '0);
        chk("cfg.ev1.count1", a_count[127:64], 64'd2);
        drive(ev(2'd1), '0, '0);
        chk("cfg.ev2.count1", a_count[127:64], 64'd3);
        chk("cfg.ev2.tick1",  {63'd0, a_tick[1]}, 64'd1);

        // ---- B: ch1 to count 5 with overflow, then clear with an event ----
        drive('0, wr(2'd1, 4'd0), '0);
        for (int i = 0; i < 21; i++) drive('0, ev(2'd1), '0);
        chk("pre_clr.B.count1", {60'd0, b_count[7:4]}, 64'd5);
        chk("pre_clr.B.ovf1",   {63'd0, b_ovf[1]},     64'd1);
        drive('0, ev(2'd0), '0);
        drive('0, ev(2'd0), '0);
        s = ev(2'd1); s.clr = 3'b010;
        drive('0, s, '0);
        chk("clr.B.count1", {60'd0, b_count[7:4]}, 64'd0);
        chk("clr.B.ovf1",   {63'd0, b_ovf[1]},     64'd0);
        chk("clr.B.count0", {60'd0, b_count[3:0]}, 64'd3);
        drive('0, ev(2'd0), '0);
        chk("clr.B.count0_next", {60'd0, b_count[3:0]}, 64'd4);
        drive('0, ev(2'd1), '0);
        chk("clr.B.div1_kept", {60'd0, b_count[7:4]}, 64'd1);

        // ---- B: out-of-range select and write touch nothing ----
        for (int i = 0; i < 8; i++) drive('0, ev(2'd3), '0);
        drive('0, wr(2'd3, 4'd5), '0);
        chk("oor.B.count", {52'd0, b_count}, {52'd0, 4'd0, 4'd1, 4'd4});
        chk("oor.B.tick",  {61'd0, b_tick},  64'd0);
        drive('0, ev(2'd1), '0);
        chk("oor.B.div1", {60'd0, b_count[7:4]}, 64'd2);
        for (int i = 1; i <= 4; i++) begin
            drive('0, ev(2'd2), '0);
            if (i == 3) chk("oor.B.div2_3", {60'd0, b_count[11:8]}, 64'd0);
            if (i == 4) chk("oor.B.div2_4", {60'd0, b_count[11:8]}, 64'd1);
        end
        drive('0, ev(2'd0), '0);
        chk("oor.B.div0", {60'd0, b_count[3:0]}, 64'd5);

        // ---- A: reset mid-run restores dividers ----
        s = '0; s.clr = 3'b001;
        drive(s, '0, '0);
        for (int i = 0; i < 7; i++) drive(ev(2'd0), '0, '0);
        drive(wr(2'd1, 4'd7), '0, '0);
        chk("mid.count0", a_count[63:0],   64'd7);
        chk("mid.count1", a_count[127:64], 64'd3);
        s = '0; s.rst = 1'b1;
        drive(s, '0, '0);
        chk("mid_rst.count", a_count[63:0] | a_count[127:64], 64'd0);
        chk("mid_rst.ovf_tick", {60'd0, a_ovf, a_tick}, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            drive(ev(2'd1), '0, '0);
            if (i == 3) chk("mid_rst.div1_3", a_count[127:64], 64'd0);
            if (i == 4) chk("mid_rst.div1_4", a_count[127:64], 64'd1);
        end
        drive(ev(2'd0), '0, '0);
        chk("mid_rst.div0", a_count[63:0], 64'd1);

        drive('0, '0, '0);
        drive('0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
